// File: rtl/imem_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : imem_prefetch
// Brief    : Instruction memory with pipelined synchronous read, prefetch FIFO,
//            redirect (flush/refetch) and a program-load write port.
// Revision : 1.0
// ============================================================================
module imem_prefetch #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter int                DEPTH      = 64,
  parameter int                RD_LAT     = 1,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redirect_valid,
  input  logic [ADDR_W-1:0]             redirect_pc,
  output logic                          instr_valid,
  output logic [DATA_W-1:0]             instr,
  output logic [ADDR_W-1:0]             instr_pc,
  input  logic                          instr_ready,
  output logic                          misalign_err,
  output logic                          oob_err,
  input  logic                          load_we,
  input  logic [ADDR_W-1:0]             load_addr,
  input  logic [DATA_W-1:0]             load_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int C_MAW = $clog2(DEPTH);
  localparam int C_FAW = $clog2(FIFO_DEPTH);
  localparam int C_SW  = C_FAW + 2;
  localparam logic [C_SW-1:0] C_FIFO_DEPTH = C_SW'(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [RD_LAT-1:0] r_st_valid;
  logic [RD_LAT-1:0] r_st_epoch;
  logic [RD_LAT-1:0] r_st_oob;
  logic [ADDR_W-1:0] r_st_pc   [RD_LAT];
  logic [DATA_W-1:0] r_st_data [RD_LAT];

  logic [DATA_W-1:0]     r_fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0]     r_fifo_pc   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_oob;
  logic [C_FAW:0]        r_wr_ptr;
  logic [C_FAW:0]        r_rd_ptr;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_epoch;
  logic              r_misalign;

  logic [C_MAW-1:0] w_fetch_idx;
  logic             w_fetch_oob;
  logic [C_MAW-1:0] w_load_idx;
  logic             w_load_oob;
  logic [C_SW-1:0]  w_inflight;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic [C_FAW-1:0] w_wr_idx;
  logic [C_FAW-1:0] w_rd_idx;
  logic             w_unused;

  assign w_fetch_idx = r_fetch_pc[2 +: C_MAW];
  assign w_fetch_oob = |r_fetch_pc[ADDR_W-1:2+C_MAW];
  assign w_load_idx  = load_addr[2 +: C_MAW];
  assign w_load_oob  = |load_addr[ADDR_W-1:2+C_MAW];
  assign w_unused    = &{1'b0, load_addr[1:0]};

  assign w_wr_idx    = r_wr_ptr[C_FAW-1:0];
  assign w_rd_idx    = r_rd_ptr[C_FAW-1:0];
  assign fifo_count  = r_wr_ptr - r_rd_ptr;
  assign instr_valid = (r_wr_ptr != r_rd_ptr);

  // In-flight reads of either epoch hold a credit until they leave the pipe.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + C_SW'(r_st_valid[i]);
    end
  end

  assign w_issue = !load_we && !redirect_valid &&
                   (({1'b0, fifo_count} + w_inflight) < C_FIFO_DEPTH);
  assign w_push  = r_st_valid[RD_LAT-1] && (r_st_epoch[RD_LAT-1] == r_epoch) &&
                   !redirect_valid;
  assign w_pop   = instr_valid && instr_ready && !redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_epoch    <= 1'b0;
      r_misalign <= 1'b0;
      r_st_valid <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_misalign    <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      r_st_valid[0] <= w_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        r_st_valid[i] <= r_st_valid[i-1];
      end
      if (redirect_valid) begin
        r_epoch    <= ~r_epoch;
        r_fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
        if (w_push)  r_wr_ptr   <= r_wr_ptr + 1'b1;
        if (w_pop)   r_rd_ptr   <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Datapath storage needs no reset; validity is tracked by the control state.
  always_ff @(posedge clk) begin
    if (load_we && !w_load_oob) r_mem[w_load_idx] <= load_data;
    r_st_data[0]  <= w_fetch_oob ? '0 : r_mem[w_fetch_idx];
    r_st_pc[0]    <= r_fetch_pc;
    r_st_oob[0]   <= w_fetch_oob;
    r_st_epoch[0] <= r_epoch;
    for (int i = 1; i < RD_LAT; i++) begin
      r_st_data[i]  <= r_st_data[i-1];
      r_st_pc[i]    <= r_st_pc[i-1];
      r_st_oob[i]   <= r_st_oob[i-1];
      r_st_epoch[i] <= r_st_epoch[i-1];
    end
    if (w_push) begin
      r_fifo_data[w_wr_idx] <= r_st_data[RD_LAT-1];
      r_fifo_pc[w_wr_idx]   <= r_st_pc[RD_LAT-1];
      r_fifo_oob[w_wr_idx]  <= r_st_oob[RD_LAT-1];
    end
  end

  assign instr        = instr_valid ? r_fifo_data[w_rd_idx] : '0;
  assign instr_pc     = instr_valid ? r_fifo_pc[w_rd_idx]   : '0;
  assign oob_err      = instr_valid & r_fifo_oob[w_rd_idx];
  assign misalign_err = r_misalign;

endmodule
`default_nettype wire
